// File: rtl/uart_inpr_pkg.sv
// Shared types and defaults for the UART serial input bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a. UART_INPR_PARITY_EN adds the PARITY receive state.
package uart_inpr_pkg;

    localparam int DEF_CLKS_PER_BIT    = 16;
    localparam int DEF_FIFO_DEPTH_LOG2 = 3;

    // Receive FSM states; PARITY exists only when even parity is on the wire
    typedef enum logic [2:0] {
        ST_WAIT_IDLE = 3'd0,
        ST_IDLE      = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
        ST_STOP      = 3'd4
`ifdef UART_INPR_PARITY_EN
        , ST_PARITY  = 3'd5
`endif
    } rx_state_t;

endpackage

// File: rtl/uart_inpr_fifo.sv
// Synchronous receive FIFO holding bytes between the UART receiver and INPR delivery.
// Latency: a pushed byte is visible at head/level one clk after the push edge.
// Backpressure: push while full is dropped unless a pop happens on the same edge.
module uart_inpr_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_dat,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty
);

    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LVL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_pop;
    logic                  do_push;

    // A pop frees a slot on the same edge, so push+pop is accepted even when full
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (level == LVL_FULL);
    assign empty   = (level == '0);
    assign head    = mem[rd_ptr];

    // Storage write; contents need no reset because level gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally modulo depth
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_inpr_bridge.sv
// UART (8N1, or 8E1 with UART_INPR_PARITY_EN) receiver feeding the CPU INPR/FGI input port.
// Latency: 2 clk sync + frame; stop-bit sample to fgi_set_n low is 2 clks with an empty FIFO.
// Backpressure: bytes wait in the FIFO while fgi==1; a byte arriving with the FIFO full is dropped (overrun).
module uart_inpr_bridge
    import uart_inpr_pkg::*;
#(
    parameter int CLKS_PER_BIT    = DEF_CLKS_PER_BIT,
    parameter int FIFO_DEPTH_LOG2 = DEF_FIFO_DEPTH_LOG2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       uart_rxd,
    input  logic                       fgi,
    output logic                       fgi_set_n,
    output logic [7:0]                 inpr,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
    output logic                       frame_err,
    output logic                       overrun,
    output logic                       parity_err
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic            rxd_m;
    logic            rxd_s;
    rx_state_t       state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            push_vld;
    logic [7:0]      push_dat;
    logic [7:0]      fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            deliver;
    logic            frame_bad;
`ifdef UART_INPR_PARITY_EN
    logic            par_acc;
    logic            par_bad;
    assign frame_bad = par_bad;
`else
    assign frame_bad  = 1'b0;
    assign parity_err = 1'b0;
`endif

    // Two-flop synchronizer; resets to the idle-high line level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= uart_rxd;
            rxd_s <= rxd_m;
        end
    end

    // Receive FSM: mid-bit sampling, byte push is registered one clk after the stop sample
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_WAIT_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            push_vld  <= 1'b0;
            push_dat  <= '0;
            frame_err <= 1'b0;
`ifdef UART_INPR_PARITY_EN
            par_acc    <= 1'b0;
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            push_vld <= 1'b0;
            case (state)
                // Need a full bit time of idle line before trusting a falling edge
                ST_WAIT_IDLE: begin
                    if (!rxd_s) begin
                        cnt <= '0;
                    end else if (cnt == CNT_BIT) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_IDLE: begin
                    if (!rxd_s) begin
                        cnt   <= CNT_HALF;
                        state <= ST_START;
                    end
                end
                // Re-check the start bit at its centre; a high line means a glitch
                ST_START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else if (rxd_s) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt     <= CNT_BIT;
                        bit_idx <= '0;
                        state   <= ST_DATA;
`ifdef UART_INPR_PARITY_EN
                        par_acc <= 1'b0;
`endif
                    end
                end
                ST_DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        shreg <= {rxd_s, shreg[7:1]};
                        cnt   <= CNT_BIT;
`ifdef UART_INPR_PARITY_EN
                        par_acc <= par_acc ^ rxd_s;
`endif
                        if (bit_idx == 3'd7) begin
`ifdef UART_INPR_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_INPR_PARITY_EN
                // Even parity: data bits XOR parity bit must be 0
                ST_PARITY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        par_bad <= par_acc ^ rxd_s;
                        cnt     <= CNT_BIT;
                        state   <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
`ifdef UART_INPR_PARITY_EN
                        if (par_bad) parity_err <= 1'b1;
`endif
                        if (rxd_s) begin
                            push_vld <= !frame_bad;
                            push_dat <= shreg;
                            state    <= ST_IDLE;
                        end else begin
                            // Line low at stop: wait for a real idle so a break yields one error
                            frame_err <= 1'b1;
                            cnt       <= '0;
                            state     <= ST_WAIT_IDLE;
                        end
                    end
                end
                default: state <= ST_WAIT_IDLE;
            endcase
        end
    end

    // Hand a byte over only when the CPU flag is clear and no pulse is in flight
    assign deliver = !fifo_empty && !fgi && fgi_set_n;

    uart_inpr_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .WIDTH      (8)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_vld),
        .push_dat (push_dat),
        .pop      (deliver),
        .head     (fifo_head),
        .level    (fifo_level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // One-clk active-low set pulse with inpr latched from the FIFO head
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fgi_set_n <= 1'b1;
            inpr      <= '0;
        end else begin
            fgi_set_n <= 1'b1;
            if (deliver) begin
                fgi_set_n <= 1'b0;
                inpr      <= fifo_head;
            end
        end
    end

    // Sticky overrun when a byte arrives with no room and no simultaneous pop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (push_vld && fifo_full && !deliver) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_inpr_bridge.sv
// Self-checking bench for uart_inpr_bridge: scripted scenarios plus random frames.
// Expected bytes come from a queue model of the receive FIFO; a monitor checks each pulse.
// Build with UART_INPR_PARITY_EN defined to include the parity scenario.
module tb_uart_inpr_bridge;

    localparam int CPB   = 16;
    localparam int DL2   = 3;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       uart_rxd;
    logic       fgi;
    logic       fgi_set_n;
    logic [7:0] inpr;
    logic [3:0] fifo_level;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int         vectors    = 0;
    int         miscompares = 0;
    int         pulse_cnt  = 0;
    logic [7:0] model_q[$];
    logic       exp_overrun = 1'b0;
    logic       prev_low    = 1'b0;
    logic [7:0] exp_b;

    uart_inpr_bridge #(
        .CLKS_PER_BIT    (CPB),
        .FIFO_DEPTH_LOG2 (DL2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rxd   (uart_rxd),
        .fgi        (fgi),
        .fgi_set_n  (fgi_set_n),
        .inpr       (inpr),
        .fifo_level (fifo_level),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    // Pulse monitor: every delivery must be a single-clk pulse carrying the oldest modelled byte
    always @(negedge clk) begin
        if (fgi_set_n === 1'b0) begin
            pulse_cnt++;
            vectors++;
            if (prev_low) begin
                miscompares++;
                $display("FAIL pulse_width: fgi_set_n low on consecutive clks, required single-clk pulse");
            end
            vectors++;
            if (model_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: inpr=%h delivered, required no delivery", inpr);
            end else begin
                exp_b = model_q.pop_front();
                if (inpr !== exp_b) begin
                    miscompares++;
                    $display("FAIL deliver_byte: inpr=%h, required %h", inpr, exp_b);
                end
            end
        end
        prev_low = (fgi_set_n === 1'b0);
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic b, input int n);
        uart_rxd = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        drive(1'b1, n);
    endtask

    // par_flip corrupts the parity bit; it only matters when parity is on the wire
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        logic good;
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(d[i], CPB);
`ifdef UART_INPR_PARITY_EN
        drive((^d) ^ par_flip, CPB);
`endif
        good = stop_bit && !par_flip;
        if (good) begin
            if (model_q.size() < DEPTH) model_q.push_back(d);
            else exp_overrun = 1'b1;
        end
        drive(stop_bit, CPB);
    endtask

    task automatic pulse_fgi_low();
        fgi = 1'b0;
        @(negedge clk);
        fgi = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        vectors++;
        if (inpr !== 8'h00) begin miscompares++; $display("FAIL %s_inpr: got %h, required 00", tag, inpr); end
        vectors++;
        if (fgi_set_n !== 1'b1) begin miscompares++; $display("FAIL %s_fgi_set_n: got %b, required 1", tag, fgi_set_n); end
        vectors++;
        if (fifo_level !== 4'd0) begin miscompares++; $display("FAIL %s_level: got %0d, required 0", tag, fifo_level); end
        vectors++;
        if (frame_err !== 1'b0) begin miscompares++; $display("FAIL %s_frame_err: got %b, required 0", tag, frame_err); end
        vectors++;
        if (overrun !== 1'b0) begin miscompares++; $display("FAIL %s_overrun: got %b, required 0", tag, overrun); end
        vectors++;
        if (parity_err !== 1'b0) begin miscompares++; $display("FAIL %s_parity_err: got %b, required 0", tag, parity_err); end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        uart_rxd = 1'b1;
        fgi      = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        model_q.delete();
        exp_overrun = 1'b0;
    endtask

    task automatic test_glitch_first();
        int p0;
        idle(20);
        p0 = pulse_cnt;
        drive(1'b0, 3);
        idle(20);
        vectors++;
        if (pulse_cnt !== p0) begin miscompares++; $display("FAIL glitch_pulse: got %0d pulses, required %0d", pulse_cnt, p0); end
        vectors++;
        if (fifo_level !== 4'd0) begin miscompares++; $display("FAIL glitch_level: got %0d, required 0", fifo_level); end
        send_frame(8'h41, 1'b1, 1'b0);
        idle(4);
        vectors++;
        if (pulse_cnt !== p0 + 1) begin miscompares++; $display("FAIL first_pulse: got %0d pulses, required %0d", pulse_cnt, p0 + 1); end
        vectors++;
        if (fifo_level !== 4'd0) begin miscompares++; $display("FAIL first_level: got %0d, required 0", fifo_level); end
    endtask

    task automatic test_buffering();
        int p0;
        fgi = 1'b1;
        p0  = pulse_cnt;
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'hAA, 1'b1, 1'b0);
        send_frame(8'h0A, 1'b1, 1'b0);
        idle(4);
        vectors++;
        if (fifo_level !== 4'd3) begin miscompares++; $display("FAIL buffer_level: got %0d, required 3", fifo_level); end
        vectors++;
        if (pulse_cnt !== p0) begin miscompares++; $display("FAIL buffer_hold: got %0d pulses, required %0d", pulse_cnt, p0); end
        for (int k = 0; k < 3; k++) begin
            pulse_fgi_low();
            vectors++;
            if (pulse_cnt !== p0 + k + 1) begin
                miscompares++;
                $display("FAIL buffer_one_per_clear: got %0d pulses, required %0d", pulse_cnt, p0 + k + 1);
            end
        end
        vectors++;
        if (fifo_level !== 4'd0) begin miscompares++; $display("FAIL buffer_drain: got %0d, required 0", fifo_level); end
    endtask

    task automatic test_overrun();
        int p0;
        fgi = 1'b1;
        p0  = pulse_cnt;
        for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, 1'b0);
        idle(4);
        vectors++;
        if (fifo_level !== 4'd8) begin miscompares++; $display("FAIL overrun_level: got %0d, required 8", fifo_level); end
        vectors++;
        if (overrun !== exp_overrun) begin miscompares++; $display("FAIL overrun_flag: got %b, required %b", overrun, exp_overrun); end
        pulse_fgi_low();
        vectors++;
        if (pulse_cnt !== p0 + 1) begin miscompares++; $display("FAIL overrun_first: got %0d pulses, required %0d", pulse_cnt, p0 + 1); end
        fgi = 1'b0;
        idle(30);
        vectors++;
        if (pulse_cnt !== p0 + 8) begin miscompares++; $display("FAIL overrun_total: got %0d pulses, required %0d", pulse_cnt, p0 + 8); end
        vectors++;
        if (fifo_level !== 4'd0) begin miscompares++; $display("FAIL overrun_drain: got %0d, required 0", fifo_level); end
    endtask

    task automatic test_frame_err();
        int p0;
        fgi = 1'b0;
        p0  = pulse_cnt;
        send_frame(8'h33, 1'b0, 1'b0);
        drive(1'b0, 40);
        idle(20);
        vectors++;
        if (frame_err !== 1'b1) begin miscompares++; $display("FAIL frame_err_flag: got %b, required 1", frame_err); end
        vectors++;
        if (pulse_cnt !== p0) begin miscompares++; $display("FAIL frame_err_drop: got %0d pulses, required %0d", pulse_cnt, p0); end
        send_frame(8'h34, 1'b1, 1'b0);
        idle(4);
        vectors++;
        if (pulse_cnt !== p0 + 1) begin miscompares++; $display("FAIL frame_err_recover: got %0d pulses, required %0d", pulse_cnt, p0 + 1); end
    endtask

    task automatic test_reset_midframe();
        int         p0;
        logic [7:0] d;
        d   = 8'h7E;
        fgi = 1'b0;
        drive(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive(d[i], CPB);
        drive(d[4], CPB / 2);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values("midreset");
        rst_n = 1'b1;
        model_q.delete();
        exp_overrun = 1'b0;
        p0 = pulse_cnt;
        idle(40);
        vectors++;
        if (pulse_cnt !== p0) begin miscompares++; $display("FAIL midreset_nobyte: got %0d pulses, required %0d", pulse_cnt, p0); end
        send_frame(8'h21, 1'b1, 1'b0);
        idle(4);
        vectors++;
        if (pulse_cnt !== p0 + 1) begin miscompares++; $display("FAIL midreset_next: got %0d pulses, required %0d", pulse_cnt, p0 + 1); end
    endtask

`ifdef UART_INPR_PARITY_EN
    task automatic test_parity();
        int p0;
        fgi = 1'b0;
        p0  = pulse_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        idle(4);
        vectors++;
        if (parity_err !== 1'b1) begin miscompares++; $display("FAIL parity_flag: got %b, required 1", parity_err); end
        vectors++;
        if (pulse_cnt !== p0) begin miscompares++; $display("FAIL parity_drop: got %0d pulses, required %0d", pulse_cnt, p0); end
        send_frame(8'h07, 1'b1, 1'b0);
        idle(4);
        vectors++;
        if (pulse_cnt !== p0 + 1) begin miscompares++; $display("FAIL parity_good: got %0d pulses, required %0d", pulse_cnt, p0 + 1); end
    endtask
`endif

    // Random bytes, gaps and CPU flag; fgi is forced low before the model could fill
    task automatic test_random();
        int p0;
        int n_sent;
        p0     = pulse_cnt;
        n_sent = 0;
        for (int n = 0; n < 16; n++) begin
            fgi = (model_q.size() >= 5) ? 1'b0 : 1'($urandom_range(0, 1));
            idle($urandom_range(1, 30));
            send_frame(8'($urandom), 1'b1, 1'b0);
            n_sent++;
        end
        fgi = 1'b0;
        idle(30);
        vectors++;
        if (pulse_cnt !== p0 + n_sent) begin miscompares++; $display("FAIL random_count: got %0d pulses, required %0d", pulse_cnt - p0, n_sent); end
        vectors++;
        if (fifo_level !== 4'd0) begin miscompares++; $display("FAIL random_level: got %0d, required 0", fifo_level); end
        vectors++;
        if (overrun !== exp_overrun) begin miscompares++; $display("FAIL random_overrun: got %b, required %b", overrun, exp_overrun); end
    endtask

    initial begin
        test_reset();
        test_glitch_first();
        test_buffering();
        test_overrun();
        test_frame_err();
        test_reset_midframe();
`ifdef UART_INPR_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
